// File: rtl/instr_mem_pkg.sv
// Shared constants, FSM state type and parity helper for the instruction memory responder.
package instr_mem_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 16;

  localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    SERVE = 2'd3
  } state_t;

  // Even parity: stored bit makes the XOR over data plus parity equal zero.
  function automatic logic even_par(input logic [WORD_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/instr_ram.sv
// Synchronous 1R1W program store: registered read, write at the clock edge, no reset on array or read data.
module instr_ram
  import instr_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = WORD_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Load port write
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  // Registered read; a same-edge write is not visible until the next read
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_idx];
    end
  end

endmodule

// File: rtl/instr_mem.sv
// Instruction memory responder for the IF stage: address change is the request, InstrStall gates validity.
// Optional build macro INSTR_MEM_PARITY_EN adds a stored even-parity bit checked when a word is served.
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                     Clock,
  input  logic                     nReset,
  input  logic [ADDR_W-1:0]        InstrAddr,
  output logic [WORD_W-1:0]        InstrMem,
  output logic                     InstrStall,
  output logic                     InstrErr,
  input  logic                     LoadEn,
  input  logic [$clog2(DEPTH)-1:0] LoadAddr,
  input  logic [WORD_W-1:0]        LoadData
);

  localparam int IDX_W = $clog2(DEPTH);
`ifdef INSTR_MEM_PARITY_EN
  localparam int RAM_W = WORD_W + 1;
`else
  localparam int RAM_W = WORD_W;
`endif

  state_t              state_r;
  state_t              cur_s;
  logic [3:0]          cnt_r;
  logic [ADDR_W-1:0]   fetch_addr_r;
  logic [ADDR_W-1:0]   served_addr_r;
  logic                served_valid_r;
  logic                out_ok_r;
  logic                err_r;
  logic [IDX_W-1:0]    idx_s;
  logic                addr_err_s;
  logic                hit_s;
  logic                done_s;
  logic                rd_en_s;
  logic                perr_s;
  logic [RAM_W-1:0]    wr_word_s;
  logic [RAM_W-1:0]    ram_q_s;

  assign idx_s      = InstrAddr[IDX_W+1:2];
  assign addr_err_s = (InstrAddr[1:0] != 2'b00) || ((InstrAddr >> (IDX_W + 2)) != 16'd0);
  assign hit_s      = LoadEn && (LoadAddr == idx_s);
  assign rd_en_s    = (cur_s == FETCH) || (cur_s == WAIT);

`ifdef INSTR_MEM_PARITY_EN
  assign wr_word_s = {even_par(LoadData), LoadData};
  assign perr_s    = out_ok_r && (ram_q_s[WORD_W] != even_par(ram_q_s[WORD_W-1:0]));
`else
  assign wr_word_s = LoadData;
  assign perr_s    = 1'b0;
`endif

  // The RAM read register is the output data register, so the mux only blanks it; this keeps zero-wait fetch at one cycle.
  assign InstrMem   = (out_ok_r && !perr_s) ? ram_q_s[WORD_W-1:0] : NOP;
  assign InstrErr   = err_r || perr_s;
  assign InstrStall = !(served_valid_r && (InstrAddr == served_addr_r));

  // Effective state this cycle: a new or changed address turns the cycle into FETCH immediately
  always_comb begin
    cur_s = state_r;
    case (state_r)
      EMPTY: cur_s = FETCH;
      FETCH: cur_s = FETCH;
      WAIT: begin
        if (InstrAddr != fetch_addr_r) cur_s = FETCH;
        else                           cur_s = WAIT;
      end
      SERVE: begin
        if (!served_valid_r || (InstrAddr != served_addr_r)) cur_s = FETCH;
        else                                                 cur_s = SERVE;
      end
      default: cur_s = FETCH;
    endcase
  end

  // Read completes at the coming edge when no further wait cycles remain
  always_comb begin
    done_s = 1'b0;
    if (cur_s == FETCH) begin
      done_s = (WAIT_STATES == 0);
    end else if (cur_s == WAIT) begin
      done_s = (cnt_r == 4'd1);
    end else begin
      done_s = 1'b0;
    end
  end

  // Fetch FSM, wait counter and served-word bookkeeping
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_r        <= EMPTY;
      cnt_r          <= 4'd0;
      fetch_addr_r   <= 16'd0;
      served_addr_r  <= 16'd0;
      served_valid_r <= 1'b0;
      out_ok_r       <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      case (cur_s)
        FETCH: begin
          fetch_addr_r <= InstrAddr;
          cnt_r        <= 4'(WAIT_STATES);
        end
        WAIT:    cnt_r <= cnt_r - 4'd1;
        default: cnt_r <= cnt_r;
      endcase

      // A load to the served or in-flight word invalidates it and forces a re-read
      if (hit_s) begin
        state_r        <= FETCH;
        served_valid_r <= 1'b0;
        out_ok_r       <= 1'b0;
        err_r          <= 1'b0;
      end else if (done_s) begin
        state_r        <= SERVE;
        served_addr_r  <= InstrAddr;
        served_valid_r <= 1'b1;
        out_ok_r       <= !addr_err_s;
        err_r          <= addr_err_s;
      end else if (cur_s == FETCH) begin
        state_r        <= WAIT;
        served_valid_r <= 1'b0;
        out_ok_r       <= 1'b0;
        err_r          <= 1'b0;
      end else begin
        state_r <= cur_s;
      end
    end
  end

  instr_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RAM_W),
    .AW    (IDX_W)
  ) u_ram (
    .clk     (Clock),
    .wr_en   (LoadEn),
    .wr_idx  (LoadAddr),
    .wr_data (wr_word_s),
    .rd_en   (rd_en_s),
    .rd_idx  (idx_s),
    .rd_data (ram_q_s)
  );

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem: a zero-wait and a three-wait instance share clock, reset and load port.
module tb_instr_mem;

  logic        clk;
  logic        rst_n;
  logic [15:0] a0, a3;
  logic [31:0] m0, m3;
  logic        s0, s3, e0, e3;
  logic        le;
  logic [9:0]  la;
  logic [31:0] ld;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] img [0:8];

  instr_mem #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .Clock(clk), .nReset(rst_n), .InstrAddr(a0), .InstrMem(m0), .InstrStall(s0),
    .InstrErr(e0), .LoadEn(le), .LoadAddr(la), .LoadData(ld)
  );

  instr_mem #(.DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
    .Clock(clk), .nReset(rst_n), .InstrAddr(a3), .InstrMem(m3), .InstrStall(s3),
    .InstrErr(e3), .LoadEn(le), .LoadAddr(la), .LoadData(ld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic load_word(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    le = 1'b1; la = idx; ld = data;
    @(negedge clk);
    le = 1'b0;
  endtask

  // Present addr to one instance, expect stall for 1+WAIT_STATES cycles, then the word
  task automatic fetch_chk(input int which, input string tag, input logic [15:0] addr,
                           input logic [31:0] exp_word, input logic exp_err);
    int n_stall;
    n_stall = (which == 0) ? 1 : 4;
    @(negedge clk);
    if (which == 0) a0 = addr; else a3 = addr;
    for (int k = 0; k < n_stall; k++) begin
      #1;
      check({tag, "_stall"}, (which == 0) ? 32'(s0) : 32'(s3), 32'd1);
      @(negedge clk);
    end
    #1;
    check({tag, "_valid"}, (which == 0) ? 32'(s0) : 32'(s3), 32'd0);
    check({tag, "_data"},  (which == 0) ? m0 : m3, exp_word);
    check({tag, "_err"},   (which == 0) ? 32'(e0) : 32'(e3), 32'(exp_err));
  endtask

  initial begin
    rst_n = 1'b0; a0 = 16'h0000; a3 = 16'h0000;
    le = 1'b0; la = 10'd0; ld = 32'h0000_0000;
    img[0] = 32'h2002_0005; img[1] = 32'h1111_0001; img[2] = 32'h2222_0002;
    img[3] = 32'h3333_0003; img[4] = 32'h4444_0004; img[5] = 32'h5555_0005;
    img[6] = 32'h6666_0006; img[7] = 32'h7777_0007; img[8] = 32'h8888_0008;

    for (int i = 0; i < 9; i++) load_word(10'(i), img[i]);

    // Reset state
    @(negedge clk); #1;
    check("rst_mem0", m0, 32'h0000_0000);
    check("rst_err0", 32'(e0), 32'd0);
    check("rst_stall0", 32'(s0), 32'd1);
    check("rst_stall3", 32'(s3), 32'd1);

    // Test 1: first fetch of address 0 after reset, zero wait states
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t1_stall", 32'(s0), 32'd1);
    @(negedge clk); #1;
    check("t1_valid", 32'(s0), 32'd0);
    check("t1_data", m0, 32'h2002_0005);
    check("t1_err", 32'(e0), 32'd0);

    // Test 2: three wait states, sequential words
    fetch_chk(1, "t2a", 16'h0004, 32'h1111_0001, 1'b0);
    fetch_chk(1, "t2b", 16'h0008, 32'h2222_0002, 1'b0);

    // Test 3: misaligned and out-of-range addresses, then recovery
    fetch_chk(0, "t3_misalign", 16'h0006, 32'h0000_0000, 1'b1);
    fetch_chk(0, "t3_range", 16'h1000, 32'h0000_0000, 1'b1);
    fetch_chk(0, "t3_recover", 16'h0004, 32'h1111_0001, 1'b0);

    // Test 4: address changes during WAIT; 0x0010 never becomes valid
    @(negedge clk);
    a3 = 16'h0010;
    #1;
    check("t4_abandon0", 32'(s3), 32'd1);
    @(negedge clk); #1;
    check("t4_abandon1", 32'(s3), 32'd1);
    fetch_chk(1, "t4_new", 16'h0020, 32'h8888_0008, 1'b0);

    // Test 5: loads to another word leave the served word alone; a load to it refetches
    fetch_chk(0, "t5_pre", 16'h000C, 32'h3333_0003, 1'b0);
    load_word(10'd5, 32'h5A5A_5A5A);
    #1;
    check("t5_other_stall", 32'(s0), 32'd0);
    check("t5_other_data", m0, 32'h3333_0003);
    @(negedge clk);
    le = 1'b1; la = 10'd3; ld = 32'hDEAD_BEEF;
    @(negedge clk);
    le = 1'b0;
    #1;
    check("t5_hit_stall", 32'(s0), 32'd1);
    @(negedge clk); #1;
    check("t5_new_valid", 32'(s0), 32'd0);
    check("t5_new_data", m0, 32'hDEAD_BEEF);

    // Test 6: reset during WAIT clears outputs immediately, then fetch resumes
    fetch_chk(0, "t6_pre", 16'h0006, 32'h0000_0000, 1'b1);
    @(negedge clk);
    a3 = 16'h0004;
    #1;
    check("t6_fetch", 32'(s3), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    a0 = 16'h0008;
    #1;
    check("t6_rst_mem3", m3, 32'h0000_0000);
    check("t6_rst_err3", 32'(e3), 32'd0);
    check("t6_rst_stall3", 32'(s3), 32'd1);
    check("t6_rst_mem0", m0, 32'h0000_0000);
    check("t6_rst_err0", 32'(e0), 32'd0);
    check("t6_rst_stall0", 32'(s0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t6_resume_stall", 32'(s3), 32'd1);
      if (k == 1) begin
        check("t6_resume0_valid", 32'(s0), 32'd0);
        check("t6_resume0_data", m0, 32'h2222_0002);
      end
      @(negedge clk);
    end
    #1;
    check("t6_resume_valid", 32'(s3), 32'd0);
    check("t6_resume_data", m3, 32'h1111_0001);
    check("t6_resume_err", 32'(e3), 32'd0);

`ifdef INSTR_MEM_PARITY_EN
    // Corrupt the stored parity of word 3 and refetch it
    u_dut0.u_ram.mem_r[3][32] = ~u_dut0.u_ram.mem_r[3][32];
    fetch_chk(0, "t7_perr", 16'h000C, 32'h0000_0000, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
